// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a length header, assembles big-endian words and
// writes them to instruction memory, holding the core in reset until the load finishes.
// Optional checksum byte enabled by macro PROG_LOADER_CSUM_EN.
module prog_loader #(
  parameter int MAX_WORDS = 64,
  parameter int LEN_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  // Without a checksum, FLUSH holds off DONE for one cycle so the last write commits first.
  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
`ifdef PROG_LOADER_CSUM_EN
    CSUM,
`else
    FLUSH,
`endif
    DONE,
    ERR
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [IDX_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        shift_q, shift_d;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif
  logic               rx_ready_q, rx_ready_d;
  logic               im_we_q, im_we_d;
  logic [31:0]        im_addr_q, im_addr_d;
  logic [31:0]        im_wdata_q, im_wdata_d;
  logic               core_rst_q, core_rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               xfer_s;
  logic [15:0]        hdr_s;
  logic [LEN_W-1:0]   len_s;
  logic               len_ok_s;

  assign xfer_s   = rx_valid && rx_ready_q;
  assign hdr_s    = {len_hi_q, rx_data};
  assign len_s    = LEN_W'(hdr_s);
  assign len_ok_s = (len_s != '0) && (len_s <= LEN_W'(MAX_WORDS));

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    n_d        = n_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
`ifdef PROG_LOADER_CSUM_EN
    csum_d     = xfer_s ? (csum_q ^ rx_data) : csum_q;
`endif
    im_we_d    = 1'b0;
    im_addr_d  = 32'd0;
    im_wdata_d = im_wdata_q;

    case (state_q)
      LEN_HI: begin
        if (xfer_s) begin
          len_hi_d = rx_data;
          state_d  = LEN_LO;
        end else begin
          state_d  = LEN_HI;
        end
      end
      LEN_LO: begin
        if (xfer_s) begin
          if (len_ok_s) begin
            n_d     = IDX_W'(len_s);
            state_d = DATA;
          end else begin
            state_d = ERR;
          end
        end else begin
          state_d = LEN_LO;
        end
      end
      DATA: begin
        if (xfer_s) begin
          shift_d    = {shift_q[15:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            im_we_d    = 1'b1;
            im_addr_d  = 32'(idx_q) << 2;
            im_wdata_d = {shift_q, rx_data};
            idx_d      = idx_q + IDX_W'(1);
            if (idx_q == n_q - IDX_W'(1)) begin
`ifdef PROG_LOADER_CSUM_EN
              state_d = CSUM;
`else
              state_d = FLUSH;
`endif
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      CSUM: begin
        if (xfer_s) begin
          state_d = (rx_data == csum_q) ? DONE : ERR;
        end else begin
          state_d = CSUM;
        end
      end
`else
      FLUSH:   state_d = DONE;
`endif
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase

    // Status flags are decoded from the next state so they register alongside it.
    case (state_d)
`ifdef PROG_LOADER_CSUM_EN
      LEN_HI, LEN_LO, DATA, CSUM: rx_ready_d = 1'b1;
`else
      LEN_HI, LEN_LO, DATA:       rx_ready_d = 1'b1;
`endif
      default:                    rx_ready_d = 1'b0;
    endcase
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    core_rst_d = !done_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LEN_HI;
      len_hi_q   <= 8'd0;
      n_q        <= '0;
      idx_q      <= '0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
`ifdef PROG_LOADER_CSUM_EN
      csum_q     <= 8'd0;
`endif
      rx_ready_q <= 1'b1;
      im_we_q    <= 1'b0;
      im_addr_q  <= 32'd0;
      im_wdata_q <= 32'd0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
`ifdef PROG_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
      rx_ready_q <= rx_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: header parsing, word writes, timing of done,
// error paths and reset behaviour.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  prog_loader #(.MAX_WORDS(64), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cyc = -1;
  int addr_viol = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  tx[$];
  logic [31:0] exp_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write / done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
      wr_cyc.push_back(cyc);
    end
    if (im_we === 1'b0 && im_addr !== 32'd0) addr_viol++;
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    exp_d.delete();
    done_cyc = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit acc;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = rx_ready;
      tick();
    end
    chk("rx_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_stream(input int max_gap, input bit with_csum);
    logic [7:0] x;
    x = 8'd0;
    foreach (tx[i]) begin
      send_byte(tx[i], max_gap);
      x ^= tx[i];
    end
`ifdef PROG_LOADER_CSUM_EN
    if (with_csum) send_byte(x, max_gap);
`endif
    rx_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < wr_addr.size(); i++) begin
      chk({tag, "_addr"}, wr_addr[i], 32'(i * 4));
      chk({tag, "_data"}, wr_data[i], exp_d[i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'd0;

    // Reset state
    do_reset();
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_im_we",    32'(im_we),    32'd0);
    chk("rst_im_addr",  im_addr,       32'd0);
    chk("rst_im_wdata", im_wdata,      32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);

    // Two-word load, back to back
    do_reset();
    tx = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    exp_d = '{32'h20080005, 32'hAC080000};
    send_stream(0, 1'b1);
    repeat (3) tick();
    check_writes("two");
    if (wr_cyc.size() >= 2) begin
      chk("two_gap",  32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
      chk("two_done_lat", 32'(done_cyc - wr_cyc[1]), 32'd1);
    end
    chk("two_done",     32'(done),     32'd1);
    chk("two_core_rst", 32'(core_rst), 32'd0);
    chk("two_err",      32'(err),      32'd0);
    chk("two_rx_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    repeat (5) tick();
    rx_valid = 1'b0;
    chk("done_nwr",  32'(wr_addr.size()), 32'd2);
    chk("done_hold", 32'(done), 32'd1);

    // Zero length header
    do_reset();
    tx = '{8'h00, 8'h00};
    send_stream(0, 1'b0);
    chk("zero_err",      32'(err),      32'd1);
    chk("zero_rx_ready", 32'(rx_ready), 32'd0);
    chk("zero_done",     32'(done),     32'd0);
    chk("zero_core_rst", 32'(core_rst), 32'd1);
    repeat (3) tick();
    chk("zero_err_hold", 32'(err), 32'd1);
    chk("zero_nwr", 32'(wr_addr.size()), 32'd0);

    // Length above MAX_WORDS, then reset recovery
    do_reset();
    tx = '{8'h00, 8'h41};
    send_stream(0, 1'b0);
    chk("big_err", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("big_rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("big_rst_core_rst", 32'(core_rst), 32'd1);
    chk("big_rst_err",      32'(err),      32'd0);

    // Exactly MAX_WORDS words
    do_reset();
    tx = '{8'h00, 8'h40};
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = 32'hA5000000 | (32'(i) * 32'h00010203);
      exp_d.push_back(w);
      tx.push_back(w[31:24]);
      tx.push_back(w[23:16]);
      tx.push_back(w[15:8]);
      tx.push_back(w[7:0]);
    end
    send_stream(0, 1'b1);
    repeat (2) tick();
    check_writes("max");
    chk("max_done", 32'(done), 32'd1);

    // Reset mid-word, with a byte offered during reset
    do_reset();
    tx = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_stream(0, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'hCC;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx_valid = 1'b0;
    tick();
    chk("midrst_nwr",      32'(wr_addr.size()), 32'd0);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    clear_log();
    tx = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_d = '{32'h11223344};
    send_stream(0, 1'b1);
    repeat (2) tick();
    check_writes("reload");
    chk("reload_done", 32'(done), 32'd1);

    // Three-word load with random valid gaps
    do_reset();
    tx = '{8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
           8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    exp_d = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
    send_stream(3, 1'b1);
    repeat (4) tick();
    check_writes("gap");
    chk("gap_done", 32'(done), 32'd1);

`ifdef PROG_LOADER_CSUM_EN
    // Checksum match and mismatch
    do_reset();
    tx = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    exp_d = '{32'h12345678};
    send_stream(0, 1'b0);
    tick();
    check_writes("csum_ok");
    chk("csum_ok_done", 32'(done), 32'd1);
    do_reset();
    tx = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
    exp_d = '{32'h12345678};
    send_stream(0, 1'b0);
    tick();
    check_writes("csum_bad");
    chk("csum_bad_err",  32'(err),  32'd1);
    chk("csum_bad_done", 32'(done), 32'd0);
`endif

    chk("addr_idle", 32'(addr_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
